// File: rtl/gameover_pkg.sv
// Shared types and constants for the game-over overlay fetch path.
// Imported by gameover_reveal_fsm and gameover_sprite_fetch.
package gameover_pkg;

  typedef enum logic [1:0] {
    HIDDEN,
    REVEAL,
    SHOWN
  } state_t;

  localparam logic [3:0] TRANSPARENT_IDX = 4'h0;
  localparam int         ROM_AW          = 15;
  localparam int         PIPE_LAT        = 2;

endpackage

// File: rtl/gameover_reveal_fsm.sv
// Show/reveal sequencer: top-down wipe over several frames, then steady.
// Optional blink in SHOWN when GAMEOVER_BLINK_EN is defined.
module gameover_reveal_fsm
  import gameover_pkg::*;
#(
  parameter int IMG_H        = 120,
  parameter int REVEAL_STEP  = 8,
  parameter int BLINK_FRAMES = 30
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_start,
  input  logic       show,
  output logic       visible,
  output logic [8:0] reveal_rows,
  output logic       busy
);

  localparam logic [8:0] FULL = 9'(2 * IMG_H);
  localparam logic [8:0] STEP = 9'(REVEAL_STEP);

  state_t     state;
  logic [9:0] sum;
  logic [8:0] next_rows;

  assign sum       = {1'b0, reveal_rows} + {1'b0, STEP};
  assign next_rows = (sum >= {1'b0, FULL}) ? FULL : sum[8:0];

`ifdef GAMEOVER_BLINK_EN
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

  logic [7:0] blink_cnt;
  logic       blink_on;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= HIDDEN;
      reveal_rows <= '0;
      visible     <= 1'b0;
      busy        <= 1'b0;
`ifdef GAMEOVER_BLINK_EN
      blink_cnt   <= '0;
      blink_on    <= 1'b1;
`endif
    end else if (!show) begin
      // Dropping show aborts immediately, even on a frame_start cycle
      state       <= HIDDEN;
      reveal_rows <= '0;
      visible     <= 1'b0;
      busy        <= 1'b0;
`ifdef GAMEOVER_BLINK_EN
      blink_cnt   <= '0;
      blink_on    <= 1'b1;
`endif
    end else if (frame_start) begin
      unique case (state)
        HIDDEN: begin
          state       <= REVEAL;
          reveal_rows <= '0;
          visible     <= 1'b1;
          busy        <= 1'b1;
        end
        REVEAL: begin
          reveal_rows <= next_rows;
          if (next_rows == FULL) begin
            state   <= SHOWN;
            busy    <= 1'b0;
            visible <= 1'b1;
`ifdef GAMEOVER_BLINK_EN
            blink_cnt <= '0;
            blink_on  <= 1'b1;
`endif
          end
        end
        SHOWN: begin
`ifdef GAMEOVER_BLINK_EN
          if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blink_on  <= ~blink_on;
            visible   <= ~blink_on;
          end else begin
            blink_cnt <= blink_cnt + 8'd1;
          end
`else
          visible <= 1'b1;
`endif
        end
        default: begin
          state       <= HIDDEN;
          reveal_rows <= '0;
          visible     <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/gameover_sprite_fetch.sv
// Maps scan coordinates onto a 2x-scaled game-over bitmap in ROM and emits
// a palette index plus overlay enable, 2 cycles behind the scan position.
module gameover_sprite_fetch
  import gameover_pkg::*;
#(
  parameter int IMG_W        = 160,
  parameter int IMG_H        = 120,
  parameter int X0           = 160,
  parameter int Y0           = 120,
  parameter int REVEAL_STEP  = 8,
  parameter int BLINK_FRAMES = 30
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_start,
  input  logic              show,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [3:0]        rom_q,
  output logic [3:0]        palette_index,
  output logic              overlay_en,
  output logic              busy
);

  localparam logic [9:0]        XS = 10'(X0);
  localparam logic [9:0]        YS = 10'(Y0);
  localparam logic [10:0]       XE = 11'(X0 + 2 * IMG_W);
  localparam logic [10:0]       YE = 11'(Y0 + 2 * IMG_H);
  localparam logic [ROM_AW-1:0] W  = ROM_AW'(IMG_W);

  logic       visible;
  logic [8:0] reveal_rows;
  logic [9:0] sy;
  logic [8:0] hx;
  logic       in_box;
  logic       row_ok;
  logic       in_box_d;
  logic       blank_d;
  logic       row_ok_d;

  gameover_reveal_fsm #(
    .IMG_H        (IMG_H),
    .REVEAL_STEP  (REVEAL_STEP),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_fsm (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_start (frame_start),
    .show        (show),
    .visible     (visible),
    .reveal_rows (reveal_rows),
    .busy        (busy)
  );

  // sx wraps below X0; in_box masks those columns
  assign sy = DrawY - YS;
  assign hx = 9'((DrawX - XS) >> 1);

  assign in_box = (DrawX >= XS) && ({1'b0, DrawX} < XE) &&
                  (DrawY >= YS) && ({1'b0, DrawY} < YE);

  assign row_ok = sy < {1'b0, reveal_rows};

  assign rom_addr = in_box ? (ROM_AW'(sy[9:1]) * W + ROM_AW'(hx)) : '0;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      in_box_d      <= 1'b0;
      blank_d       <= 1'b0;
      row_ok_d      <= 1'b0;
      palette_index <= '0;
      overlay_en    <= 1'b0;
    end else begin
      in_box_d      <= in_box;
      blank_d       <= blank;
      row_ok_d      <= row_ok;
      palette_index <= rom_q;
      overlay_en    <= in_box_d && blank_d && row_ok_d && visible &&
                       (rom_q != TRANSPARENT_IDX);
    end
  end

endmodule

// File: tb/tb_gameover_sprite_fetch.sv
// Directed bench for gameover_sprite_fetch (default build, blink disabled).
// Inputs change on negedge; outputs are sampled on negedge.
module tb_gameover_sprite_fetch;

  logic        Clk;
  logic        Reset;
  logic        frame_start;
  logic        show;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        blank;
  logic [14:0] rom_addr;
  logic [3:0]  rom_q;
  logic [3:0]  palette_index;
  logic        overlay_en;
  logic        busy;

  int ncmp;
  int nfail;

  int ax [9] = '{160, 161, 162, 479, 200, 159, 480, 300, 300};
  int ay [9] = '{120, 120, 120, 359, 130, 200, 200, 119, 360};
  int aa [9] = '{0,   0,   1, 19199, 820,  0,   0,   0,   0};

  gameover_sprite_fetch dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .frame_start   (frame_start),
    .show          (show),
    .DrawX         (DrawX),
    .DrawY         (DrawY),
    .blank         (blank),
    .rom_addr      (rom_addr),
    .rom_q         (rom_q),
    .palette_index (palette_index),
    .overlay_en    (overlay_en),
    .busy          (busy)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic hold(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic px(input int x, input int y, input logic [3:0] q);
    DrawX = 10'(x);
    DrawY = 10'(y);
    rom_q = q;
    hold(3);
  endtask

  task automatic frame();
    @(negedge Clk);
    frame_start = 1'b1;
    @(negedge Clk);
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    hold(2);
    if (overlay_en !== 1'b0) begin
      nfail++; $display("FAIL reset_overlay got %b want 0", overlay_en);
    end
    ncmp++;
    if (palette_index !== 4'd0) begin
      nfail++; $display("FAIL reset_palette got %0d want 0", palette_index);
    end
    ncmp++;
    if (busy !== 1'b0) begin
      nfail++; $display("FAIL reset_busy got %b want 0", busy);
    end
    ncmp++;
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic test_hidden_scan();
    logic inb;
    show = 1'b0;
    frame();
    frame();
    for (int y = 0; y < 480; y += 60) begin
      for (int x = 0; x < 640; x += 80) begin
        px(x, y, 4'd5);
        if (overlay_en !== 1'b0) begin
          nfail++; $display("FAIL hidden_overlay x=%0d y=%0d got %b want 0", x, y, overlay_en);
        end
        ncmp++;
        inb = (x >= 160) && (x < 480) && (y >= 120) && (y < 360);
        if (!inb) begin
          if (rom_addr !== 15'd0) begin
            nfail++; $display("FAIL outside_addr x=%0d y=%0d got %0d want 0", x, y, rom_addr);
          end
          ncmp++;
        end
      end
    end
    if (busy !== 1'b0) begin
      nfail++; $display("FAIL hidden_busy got %b want 0", busy);
    end
    ncmp++;
  endtask

  task automatic test_addr_map();
    for (int i = 0; i < 9; i++) begin
      DrawX = 10'(ax[i]);
      DrawY = 10'(ay[i]);
      #1;
      if (rom_addr !== 15'(aa[i])) begin
        nfail++; $display("FAIL addr_map x=%0d y=%0d got %0d want %0d", ax[i], ay[i], rom_addr, aa[i]);
      end
      ncmp++;
    end
    hold(1);
  endtask

  task automatic test_reveal();
    show = 1'b1;
    frame();
    if (busy !== 1'b1) begin
      nfail++; $display("FAIL reveal_busy_start got %b want 1", busy);
    end
    ncmp++;
    px(200, 120, 4'd5);
    if (overlay_en !== 1'b0) begin
      nfail++; $display("FAIL reveal_rows0 got %b want 0", overlay_en);
    end
    ncmp++;
    frame();
    px(200, 127, 4'd5);
    if (overlay_en !== 1'b1 || palette_index !== 4'd5) begin
      nfail++; $display("FAIL reveal_y127 got en=%b idx=%0d want en=1 idx=5", overlay_en, palette_index);
    end
    ncmp++;
    px(200, 128, 4'd5);
    if (overlay_en !== 1'b0) begin
      nfail++; $display("FAIL reveal_y128 got %b want 0", overlay_en);
    end
    ncmp++;
    for (int f = 2; f <= 29; f++) frame();
    if (busy !== 1'b1) begin
      nfail++; $display("FAIL reveal_busy_f29 got %b want 1", busy);
    end
    ncmp++;
    px(200, 351, 4'd5);
    if (overlay_en !== 1'b1) begin
      nfail++; $display("FAIL reveal_y351 got %b want 1", overlay_en);
    end
    ncmp++;
    px(200, 352, 4'd5);
    if (overlay_en !== 1'b0) begin
      nfail++; $display("FAIL reveal_y352 got %b want 0", overlay_en);
    end
    ncmp++;
    frame();
    if (busy !== 1'b0) begin
      nfail++; $display("FAIL shown_busy got %b want 0", busy);
    end
    ncmp++;
    px(200, 359, 4'd5);
    if (overlay_en !== 1'b1) begin
      nfail++; $display("FAIL shown_y359 got %b want 1", overlay_en);
    end
    ncmp++;
  endtask

  task automatic test_transparency_blank();
    px(300, 200, 4'd0);
    if (overlay_en !== 1'b0 || palette_index !== 4'd0) begin
      nfail++; $display("FAIL transparent got en=%b idx=%0d want en=0 idx=0", overlay_en, palette_index);
    end
    ncmp++;
    blank = 1'b0;
    px(300, 200, 4'd5);
    if (overlay_en !== 1'b0 || palette_index !== 4'd5) begin
      nfail++; $display("FAIL blank0 got en=%b idx=%0d want en=0 idx=5", overlay_en, palette_index);
    end
    ncmp++;
    blank = 1'b1;
    px(300, 200, 4'd5);
    if (overlay_en !== 1'b1 || palette_index !== 4'd5) begin
      nfail++; $display("FAIL shown_pix got en=%b idx=%0d want en=1 idx=5", overlay_en, palette_index);
    end
    ncmp++;
    px(100, 200, 4'd5);
    if (overlay_en !== 1'b0) begin
      nfail++; $display("FAIL left_of_box got %b want 0", overlay_en);
    end
    ncmp++;
    px(300, 200, 4'd15);
    if (overlay_en !== 1'b1 || palette_index !== 4'd15) begin
      nfail++; $display("FAIL idx15 got en=%b idx=%0d want en=1 idx=15", overlay_en, palette_index);
    end
    ncmp++;
  endtask

  task automatic test_latency();
    px(100, 200, 4'd0);
    DrawX = 10'd300;
    @(negedge Clk);
    if (overlay_en !== 1'b0) begin
      nfail++; $display("FAIL lat_c1 got %b want 0", overlay_en);
    end
    ncmp++;
    rom_q = 4'd9;
    DrawX = 10'd100;
    @(negedge Clk);
    if (overlay_en !== 1'b1 || palette_index !== 4'd9) begin
      nfail++; $display("FAIL lat_c2 got en=%b idx=%0d want en=1 idx=9", overlay_en, palette_index);
    end
    ncmp++;
    rom_q = 4'd0;
    @(negedge Clk);
    if (overlay_en !== 1'b0 || palette_index !== 4'd0) begin
      nfail++; $display("FAIL lat_c3 got en=%b idx=%0d want en=0 idx=0", overlay_en, palette_index);
    end
    ncmp++;
  endtask

  task automatic test_show_drop();
    show = 1'b0;
    hold(2);
    show = 1'b1;
    frame();
    for (int f = 1; f <= 8; f++) frame();
    px(200, 183, 4'd5);
    if (overlay_en !== 1'b1) begin
      nfail++; $display("FAIL r64_y183 got %b want 1", overlay_en);
    end
    ncmp++;
    px(200, 184, 4'd5);
    if (overlay_en !== 1'b0) begin
      nfail++; $display("FAIL r64_y184 got %b want 0", overlay_en);
    end
    ncmp++;
    px(200, 150, 4'd5);
    show = 1'b0;
    @(negedge Clk);
    if (busy !== 1'b0) begin
      nfail++; $display("FAIL drop_busy got %b want 0", busy);
    end
    ncmp++;
    @(negedge Clk);
    if (overlay_en !== 1'b0) begin
      nfail++; $display("FAIL drop_overlay got %b want 0", overlay_en);
    end
    ncmp++;
    show = 1'b1;
    frame();
    px(200, 120, 4'd5);
    if (overlay_en !== 1'b0 || busy !== 1'b1) begin
      nfail++; $display("FAIL restart_r0 got en=%b busy=%b want en=0 busy=1", overlay_en, busy);
    end
    ncmp++;
    frame();
    px(200, 127, 4'd5);
    if (overlay_en !== 1'b1) begin
      nfail++; $display("FAIL restart_y127 got %b want 1", overlay_en);
    end
    ncmp++;
    px(200, 128, 4'd5);
    if (overlay_en !== 1'b0) begin
      nfail++; $display("FAIL restart_y128 got %b want 0", overlay_en);
    end
    ncmp++;
  endtask

  task automatic test_simultaneous();
    @(negedge Clk);
    frame_start = 1'b1;
    show = 1'b0;
    @(negedge Clk);
    frame_start = 1'b0;
    if (busy !== 1'b0) begin
      nfail++; $display("FAIL simul_busy got %b want 0", busy);
    end
    ncmp++;
    show = 1'b1;
    hold(3);
    if (busy !== 1'b0) begin
      nfail++; $display("FAIL simul_wait got %b want 0", busy);
    end
    ncmp++;
  endtask

  task automatic test_async_reset();
    frame();
    frame();
    px(200, 121, 4'd7);
    if (overlay_en !== 1'b1 || palette_index !== 4'd7) begin
      nfail++; $display("FAIL pre_reset got en=%b idx=%0d want en=1 idx=7", overlay_en, palette_index);
    end
    ncmp++;
    @(negedge Clk);
    #2 Reset = 1'b1;
    #1;
    if (overlay_en !== 1'b0 || palette_index !== 4'd0 || busy !== 1'b0) begin
      nfail++; $display("FAIL async_reset got en=%b idx=%0d busy=%b want 0 0 0", overlay_en, palette_index, busy);
    end
    ncmp++;
    @(negedge Clk);
    Reset = 1'b0;
    hold(3);
    if (busy !== 1'b0) begin
      nfail++; $display("FAIL post_reset_busy got %b want 0", busy);
    end
    ncmp++;
    frame();
    px(200, 120, 4'd7);
    if (overlay_en !== 1'b0 || busy !== 1'b1) begin
      nfail++; $display("FAIL post_reset_r0 got en=%b busy=%b want en=0 busy=1", overlay_en, busy);
    end
    ncmp++;
    frame();
    px(200, 127, 4'd7);
    if (overlay_en !== 1'b1) begin
      nfail++; $display("FAIL post_reset_y127 got %b want 1", overlay_en);
    end
    ncmp++;
    px(200, 128, 4'd7);
    if (overlay_en !== 1'b0) begin
      nfail++; $display("FAIL post_reset_y128 got %b want 0", overlay_en);
    end
    ncmp++;
  endtask

  initial begin
    ncmp        = 0;
    nfail       = 0;
    Reset       = 1'b1;
    frame_start = 1'b0;
    show        = 1'b0;
    DrawX       = '0;
    DrawY       = '0;
    blank       = 1'b1;
    rom_q       = '0;
    test_reset();
    test_hidden_scan();
    test_addr_map();
    test_reveal();
    test_transparency_blank();
    test_latency();
    test_show_drop();
    test_simultaneous();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
